switch_debouncer: RTL
=====================

# switch_debouncer

Conditions the four board DIP switches before they reach the top-level LED and seven-segment logic. Each raw switch bit is brought into the HSOSC clock domain (24 MHz) through a two-flop synchroniser, then debounced by a per-bit consecutive-sample counter. The block outputs a clean level vector plus one-cycle rise and fall event pulses. Downstream logic consumes `stable` in place of the raw pins.

## Interface
Parameters:
- `WIDTH`, 4: number of switch bits.
- `DEBOUNCE_CYCLES`, 240000: consecutive differing samples needed to accept a new level (10 ms at 24 MHz). Must be ≥ 1.
- `CNT_W` (localparam): `$clog2(DEBOUNCE_CYCLES+1)`, the counter width.

Ports:
- `clk` in 1: HSOSC clock, 24 MHz.
- `reset` in 1: reset, synchronous, active-low.
- `raw` in WIDTH: asynchronous switch pins, active-high.
- `stable` out WIDTH: debounced level.
- `rise` out WIDTH: one-cycle pulse when `stable[i]` goes 0→1.
- `fall` out WIDTH: one-cycle pulse when `stable[i]` goes 1→0.
- `changed` out 1: OR-reduction of `rise | fall`, registered in the same cycle as the pulses.

## Operation
- Per bit, synchroniser: `sync1 <= raw[i]`, then `sync2 <= sync1`. Only `sync2` is ever compared.
- Per-bit FSM, states IDLE and PENDING:
  - IDLE: if `sync2 != stable[i]`, go to PENDING with `cnt = 1`. Otherwise stay in IDLE with `cnt = 0`.
  - PENDING, when `sync2 == stable[i]`: glitch rejected. Go to IDLE with `cnt = 0` and no pulse.
  - PENDING, when `sync2 != stable[i]` and `cnt == DEBOUNCE_CYCLES-1`: set `stable[i] <= sync2`, pulse `rise[i]` or `fall[i]` for one cycle, go to IDLE with `cnt = 0`.
  - PENDING, otherwise: `cnt <= cnt + 1`.
- When `DEBOUNCE_CYCLES == 1`, the first differing sample in IDLE commits immediately. That is, the commit condition is also evaluated from IDLE.
- `rise`, `fall` and `changed` are registered. In every cycle without a commit they are 0.
- Bits are fully independent. Simultaneous commits on several bits all appear in the same cycle.
- Reset (`reset == 0` at a clock edge) clears `sync1`, `sync2`, `cnt`, FSM (to IDLE), `stable`, `rise`, `fall` and `changed` to 0. Reset overrides any in-progress count.
- If `raw` is high when reset is released, the bit debounces up normally and produces a `rise` pulse. This is intended: it is the power-up event.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.

## Timing
- Take edge 0 as the first edge at which `sync1` captures a new `raw` level that then holds steady.
  - Edge 1: `sync2` takes the new level.
  - Edges 2 … D+1: D consecutive differing observations, where D = `DEBOUNCE_CYCLES`.
  - Edge D+1: `stable` updates, and `rise`/`fall`/`changed` are high for exactly the one cycle after this edge.
- Latency is therefore D+1 clock edges from the first capture.
- Any mismatch-free sample restarts the full D-sample window.
- No combinational path from `raw` to any output.

## Structure
- Package `switch_pkg` holds:
  - `CLK_HZ = 24_000_000`
  - `DEBOUNCE_MS = 10`
  - derived default `DEBOUNCE_CYCLES`
  - `typedef enum logic {IDLE, PENDING} db_state_t`
- Sub-module `debounce_bit` contains the synchroniser, counter, FSM and edge pulses for one bit. The top instantiates it with a `generate` loop over WIDTH and produces `changed` as the registered OR of the per-bit pulses.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES = 4`.
1. Hold `reset` low for 2 edges with `raw = 4'b0000`, then release and run 20 cycles → `stable`, `rise`, `fall` and `changed` all stay 0.
2. Switch `raw[0]` 0→1 cleanly → `stable = 4'b0001` at edge 5 after first capture; `rise = 4'b0001` and `changed = 1` for exactly one cycle; `fall` stays 0.
3. Drive `raw[1]` high for 3 cycles, then low → `stable[1]` stays 0 and no pulses occur.
4. Toggle `raw[2]` every 2 cycles for 10 cycles, then settle at 1 → exactly one `rise[2]` pulse, 5 edges after the final toggle is captured.
5. Starting from `stable = 4'b1000`, change `raw[3]` 1→0 and `raw[0]` 0→1 on the same edge → `stable = 4'b0001` updated in one cycle, `rise = 4'b0001`, `fall = 4'b1000`, `changed = 1`.
6. Assert `reset` mid-count (`cnt = 2`) → all outputs 0 on the next edge. Then release with `raw = 4'b1111` → `stable = 4'b1111` and `rise = 4'b1111` 5 edges later.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared constants and types for the DIP-switch conditioning block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package switch_pkg;

    localparam int CLK_HZ      = 24_000_000;
    localparam int DEBOUNCE_MS = 10;

    // Samples needed to accept a new switch level at the HSOSC rate (10 ms -> 240000).
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, consecutive-sample counter, level + edge pulses.
// Latency: DEBOUNCE_CYCLES+1 edges from first capture of a steady new level to stable/pulse.
// Backpressure: none; free-running, one sample per clock.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic evt_nxt
);

    // Count value at which the D-th consecutive differing sample is being observed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_state_t        state_q, state_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic diff;

    // Synchroniser shift path; only sync2 is ever observed by the FSM.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
    end

    // Debounce FSM: count consecutive samples differing from the accepted level.
    // In IDLE cnt is 0, so the commit test also fires there when DEBOUNCE_CYCLES == 1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        diff     = (sync2_q != stable_q);

        if (diff && (cnt_q == CNT_LAST)) begin
            stable_d = sync2_q;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
            state_d  = IDLE;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (diff) begin
                        state_d = PENDING;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                PENDING: begin
                    if (!diff) begin
                        // Glitch shorter than the window: drop it silently.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable  = stable_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    // Next-cycle event, lets the parent register an aggregate flag aligned with the pulses.
    assign evt_nxt = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH asynchronous DIP switches into clean levels plus rise/fall/changed pulses.
// Latency: DEBOUNCE_CYCLES+1 edges from first capture of a steady level; all outputs registered.
// Backpressure: none; pulses are single-cycle and must be consumed when they appear.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] evt_nxt;
    logic             changed_q, changed_d;

    // Bits are fully independent; simultaneous commits land in the same cycle.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .raw_in  (raw[i]),
            .stable  (stable[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .evt_nxt (evt_nxt[i])
        );
    end

    // Aggregate event flag computed from the per-bit next-cycle pulses.
    always_comb begin
        changed_d = |evt_nxt;
    end

    // Register changed so it is high in exactly the same cycle as rise/fall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

endmodule
